// File: rtl/stacker_pkg.sv
// Shared types and defaults for the stacker game-logic block.
package stacker_pkg;

  typedef enum logic [1:0] {
    MOVE  = 2'd0,
    PLACE = 2'd1,
    OVER  = 2'd2,
    WIN   = 2'd3
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_NUM_ROWS = 10;
  localparam int DEF_INIT_LEN = 3;

endpackage

// File: rtl/stacker_row_mem.sv
// Locked-row register file: one write port, one registered read port, sync clear-all.
import stacker_pkg::*;

module stacker_row_mem #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_ROWS = DEF_NUM_ROWS
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [3:0]       raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [NUM_ROWS];

  // The read samples the array before this cycle's write lands, so a
  // same-row write/read pair returns the previous contents.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we && (32'(waddr) < NUM_ROWS)) begin
        mem[waddr] <= wdata;
      end
      if (32'(raddr) < NUM_ROWS) begin
        rdata <= mem[raddr];
      end else begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: rtl/stacker_core.sv
// Stacker game logic: moving block, placement trimming, height tracking.
// Optional perfect-placement counter enabled by defining STACKER_PERFECT_EN.
import stacker_pkg::*;

module stacker_core #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int INIT_LEN = DEF_INIT_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_pulse,
  input  logic             btn_place,
  input  logic [3:0]       rd_row,
  output logic [3:0]       height,
  output logic [WIDTH-1:0] row_active,
  output logic [WIDTH-1:0] rd_data,
  output logic             game_over,
  output logic             game_win
`ifdef STACKER_PERFECT_EN
  ,
  output logic [3:0]       perfect_cnt
`endif
);

  localparam logic [WIDTH-1:0] INIT_MASK = ~({WIDTH{1'b1}} >> INIT_LEN);
  localparam logic [WIDTH-1:0] FULL_MASK = {WIDTH{1'b1}};
  localparam logic [3:0]       LAST_ROW  = 4'(NUM_ROWS - 1);
  localparam logic [3:0]       WIN_H     = 4'(NUM_ROWS);

  state_t           state;
  logic             dir;
  logic [WIDTH-1:0] floor_mask;
  logic [WIDTH-1:0] overlap;
  logic             restart;
  logic             mem_clr;
  logic             mem_we;

  // Bounce rule: at the wall the direction flips and the block steps
  // away from it in the same tick.
  function automatic logic [WIDTH:0] step_block(input logic [WIDTH-1:0] mask,
                                                input logic             d);
    logic [WIDTH:0] r;
    r = {d, mask};
    if (mask != FULL_MASK) begin
      if (d == DIR_RIGHT) begin
        if (mask[0]) r = {DIR_LEFT, mask << 1};
        else         r = {DIR_RIGHT, mask >> 1};
      end else begin
        if (mask[WIDTH-1]) r = {DIR_RIGHT, mask >> 1};
        else               r = {DIR_LEFT, mask << 1};
      end
    end
    return r;
  endfunction

`ifdef STACKER_PERFECT_EN
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
`endif

  assign overlap = row_active & floor_mask;
  assign restart = ((state == OVER) || (state == WIN)) && btn_place;
  assign mem_clr = rst || restart;
  assign mem_we  = (state == PLACE) && (overlap != '0);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state      <= MOVE;
      height     <= '0;
      dir        <= DIR_RIGHT;
      row_active <= INIT_MASK;
      floor_mask <= FULL_MASK;
      game_over  <= 1'b0;
      game_win   <= 1'b0;
`ifdef STACKER_PERFECT_EN
      perfect_cnt <= '0;
`endif
    end else begin
      case (state)
        MOVE: begin
          if (btn_place) begin
            state <= PLACE;
          end else if (game_pulse) begin
            {dir, row_active} <= step_block(row_active, dir);
          end
        end
        PLACE: begin
          if (overlap == '0) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else begin
            floor_mask <= overlap;
            row_active <= overlap;
            if (height == LAST_ROW) begin
              height   <= WIN_H;
              state    <= WIN;
              game_win <= 1'b1;
            end else begin
              height <= height + 4'd1;
              state  <= MOVE;
            end
          end
`ifdef STACKER_PERFECT_EN
          // Row 0 always fully overlaps the virtual floor, so it never scores.
          if ((overlap == row_active) && (overlap != '0)) begin
            if (height != '0) perfect_cnt <= sat_inc4(perfect_cnt);
          end else begin
            perfect_cnt <= '0;
          end
`endif
        end
        OVER, WIN: begin
          state <= state;
        end
        default: state <= MOVE;
      endcase
    end
  end

  stacker_row_mem #(
    .WIDTH    (WIDTH),
    .NUM_ROWS (NUM_ROWS)
  ) u_row_mem (
    .clk   (clk),
    .clr   (mem_clr),
    .we    (mem_we),
    .waddr (height),
    .wdata (overlap),
    .raddr (rd_row),
    .rdata (rd_data)
  );

endmodule

// File: doc/stacker_core.md
Name: stacker_core

Overview:
- Game-logic stage directly downstream of the game-tick divider.
- Consumes the one-cycle game_pulse tick and moves the lit block of the current row back and forth on every tick.
- On a player press it locks the row, trims it to its overlap with the row below, and advances height.
- height is fed back to the divider, which shortens the tick period as the stack grows; locked rows are exposed through a read port for the display stage.

Parameters:
- WIDTH, 8: columns per row; bit 0 is the rightmost column.
- NUM_ROWS, 10: rows needed to win; must be at most 15.
- INIT_LEN, 3: block length at game start; 1 to WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- game_pulse  in  1  one-cycle movement tick from the divider
- btn_place  in  1  one-cycle, debounced place request
- rd_row  in  4  row index for the locked-row read port
- height  out  4  number of rows locked so far; drives the divider
- row_active  out  WIDTH  position mask of the moving block
- rd_data  out  WIDTH  locked mask of row rd_row, registered, 1-cycle latency
- game_over  out  1  high while in state OVER
- game_win  out  1  high while in state WIN
- perfect_cnt  out  4  present only with the optional feature

Behaviour:
- States: MOVE, PLACE, OVER, WIN. One-hot or binary encoding is allowed.
- Reset, and restart from OVER or WIN, set:
  - state = MOVE, height = 0, dir = RIGHT;
  - row_active = INIT_LEN ones aligned to the MSB;
  - floor_mask = all ones, so row 0 always fully overlaps;
  - all row memory = 0, rd_data = 0, game_over = 0, game_win = 0.
- MOVE, on game_pulse without btn_place:
  - dir RIGHT, bit 0 clear: shift row_active right by 1.
  - dir RIGHT, bit 0 set: set dir = LEFT and shift left by 1 in the same cycle (bounce, no dwell).
  - dir LEFT uses the mirror rule on bit WIDTH-1.
  - A block whose length equals WIDTH never moves.
- MOVE, on btn_place:
  - Go to PLACE next cycle and freeze row_active.
  - If btn_place and game_pulse arrive in the same cycle, btn_place wins and no shift occurs.
- PLACE, a single cycle:
  - overlap = row_active & floor_mask.
  - overlap == 0: go to OVER; height is unchanged.
  - Otherwise: rows[height] = overlap, floor_mask = overlap, row_active = overlap, dir is retained.
  - If height == NUM_ROWS-1: height = NUM_ROWS and go to WIN.
  - Else: height = height+1 and return to MOVE.
  - game_pulse is ignored in PLACE.
- OVER and WIN:
  - row_active holds; game_pulse is ignored.
  - btn_place performs a restart on the next clock, identical to reset.
- Read port:
  - rd_data = rows[rd_row], registered.
  - rd_row >= NUM_ROWS returns 0.
  - A write and a read of the same row in one cycle return the old data.
- Widths and timing:
  - height never exceeds NUM_ROWS.
  - All outputs are registered; a height change is visible the cycle after PLACE.
  - The divider self-restarts on a height change, so no tick handshake is needed.
- rst has priority over every event, including a PLACE in progress.

Optional Feature:
- Macro: STACKER_PERFECT_EN.
- When defined:
  - perfect_cnt exists.
  - It increments, saturating at 15, on every PLACE where overlap == row_active and height > 0.
  - It clears on any trimmed placement, on reset and on restart.
  - Row 0 never counts.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package stacker_pkg holds:
  - the state enum (MOVE, PLACE, OVER, WIN);
  - the DIR_LEFT and DIR_RIGHT constants;
  - default WIDTH, NUM_ROWS and INIT_LEN.
- One sub-module, stacker_row_mem: NUM_ROWS x WIDTH register file with one write port, one registered read port, and a synchronous clear-all.

Test Plan:
- Reset, 5 ticks, no press: row_active goes 11100000, 01110000, 00111000, 00011100, 00001110, 00000111.
- One further tick, then one more: bounce gives 00001110, then 00011100; dir = LEFT.
- Press at 11100000 with height 0: rows[0] = 11100000, height = 1; a press at 01110000 then trims to 01100000 and height = 2.
- Press in the same cycle as game_pulse: no shift occurs and the pre-tick mask is locked.
- Press with zero overlap at height 3: game_over = 1, height stays 3; the next btn_place restarts with height = 0 and row_active = 11100000.
- NUM_ROWS = 10 with 10 aligned presses: game_win = 1 and height = 10. With STACKER_PERFECT_EN defined, perfect_cnt = 9 and one trimmed press clears it to 0.
